lcd_show_char: RTL
==================

Name: lcd_show_char

Overview:
- Responder side of the character-draw handshake. A string/number controller issues show_char_flag with ascii_num, start_x, start_y and en_size. This block renders one glyph on the ST7789-class LCD and answers with a show_char_done pulse.
- For each glyph it does three things:
  - sets the column/row window,
  - issues memory-write,
  - streams RGB565 pixels from the font ROM into the byte-level SPI write layer, using a wr_en/wr_done handshake.

Parameters:
- FG_COLOR, 16'h0000, RGB565 colour for font bit = 1.
- BG_COLOR, 16'hFFFF, RGB565 colour for font bit = 0.
- MAX_ASCII, 94, highest legal glyph index (ASCII − 32). Larger values render glyph 0 (space).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset. One clock; reset is synchronous and active-high.
- show_char_flag  in  1  one-cycle draw request.
- ascii_num  in  7  glyph index (ASCII − 32).
- start_x  in  9  top-left column.
- start_y  in  9  top-left row.
- en_size  in  1  1 = 16x8 font, 0 = 12x6 font.
- rom_addr  out  12  font ROM address, {size bit, glyph*H + row}.
- rom_data  in  8  ROM row bits, valid 1 cycle after rom_addr.
- wr_en  out  1  one-cycle byte write strobe to the SPI layer.
- wr_data  out  9  bit8 = DC (0 = command, 1 = data), bits7:0 = byte.
- wr_done  in  1  one-cycle pulse: SPI layer finished the current byte.
- show_char_done  out  1  one-cycle pulse: glyph fully sent.
- busy  out  1  high from request acceptance until show_char_done.

Behaviour:
- Reset values: wr_en = 0, wr_data = 0, rom_addr = 0, show_char_done = 0, busy = 0; FSM goes to IDLE.
  - Reset mid-glyph aborts immediately.
  - No done pulse is produced for the aborted glyph.
- Acceptance:
  - In IDLE, show_char_flag = 1 latches ascii_num, start_x, start_y, en_size.
  - busy rises the next cycle.
  - Flags arriving while busy are ignored (not queued).
- Glyph geometry: W = 6, H = 12 if en_size = 0; W = 8, H = 16 if en_size = 1.
  - xe = xs + W − 1 and ye = ys + H − 1, in 9-bit arithmetic with wrap; no clipping.
  - Hi byte = {7'b0, v[8]}; lo byte = v[7:0].
- Byte sequence (11 header bytes):
  - 0x2A (cmd)
  - xs_hi, xs_lo, xe_hi, xe_lo (data)
  - 0x2B (cmd)
  - ys_hi, ys_lo, ye_hi, ye_lo (data)
  - 0x2C (cmd)
- Then W*H pixels, row-major, top row first. In each row, bit0 of rom_data is the leftmost pixel and bits above W−1 are ignored. Each pixel is two data bytes: colour[15:8], then colour[7:0].
- Total bytes per glyph: 11 + 2*W*H, i.e. 155 for 12x6 and 267 for 16x8.
- Write handshake:
  - Each byte: wr_en high exactly one cycle with wr_data stable that cycle; then wait for wr_done.
  - The next wr_en is issued no earlier than the cycle after wr_done.
  - The first wr_en (0x2A) is 1 cycle after the accepting flag cycle.
  - wr_done while no byte is outstanding is ignored.
- ROM fetch:
  - rom_addr for row r is presented during the header, or during the last pixel of row r−1.
  - rom_data is registered into a row shift register before the row's first pixel.
  - ROM latency never adds stall cycles beyond the wr_done wait.
- FSM states:
  - IDLE → HDR on flag.
  - HDR → PIX after the 11th wr_done.
  - Within PIX: PIX_HI → PIX_LO per pixel, with column/row counters.
  - PIX → DONE after wr_done of the lo byte of pixel (W−1, H−1).
  - DONE → IDLE after 1 cycle.
- Completion: in DONE, show_char_done = 1 for one cycle and busy falls in the same cycle.
  - A flag in that same cycle is ignored.
  - A flag in the next cycle is accepted.
- ascii_num > MAX_ASCII is forced to 0 at latch time.

Test Plan:
- 12x6 'H' (ascii_num = 40), start_x = 128, start_y = 16, instant wr_done:
  - Header bytes 0x2A, 00, 80, 00, 85, 0x2B, 00, 10, 00, 1B, 0x2C with DC bits 0,1,1,1,1,0,1,1,1,1,0.
  - 144 pixel bytes matching the ROM model.
  - Exactly one show_char_done after byte 155.
- 16x8, start_x = 260, start_y = 300:
  - xs_hi = 01, xs_lo = 04, xe_lo = 0B; ys_hi = 01, ys_lo = 2C, ye_lo = 3B.
  - 267 bytes total.
- Random wr_done delays of 0–7 cycles:
  - Never two wr_en without an intervening wr_done.
  - Byte stream is identical to the zero-delay run.
- show_char_flag re-asserted mid-glyph, plus a spurious wr_done while IDLE:
  - No restart, no extra bytes, one done pulse.
- sys_rst asserted at byte 50:
  - Next cycle wr_en = 0, busy = 0, no done.
  - A new flag afterwards produces a clean full 155-byte sequence.
- ascii_num = 100:
  - Renders glyph 0: all bytes are BG_COLOR (FF, FF) for a blank ROM row.

Source files
------------

// File: rtl/lcd_show_char.sv
// lcd_show_char: draws one font glyph on an ST7789-class panel.
// Sets the column/row window, issues memory-write, then streams RGB565
// pixels built from font ROM rows into a byte-level SPI write layer.
// Byte handshake: wr_en is high for exactly one cycle with wr_data stable
// in that cycle; the byte stays outstanding until a wr_done pulse, and the
// next wr_en follows no earlier than the cycle after that wr_done. A wr_done
// with nothing outstanding is ignored.
module lcd_show_char #(
  parameter logic [15:0] FG_COLOR  = 16'h0000,
  parameter logic [15:0] BG_COLOR  = 16'hFFFF,
  parameter int          MAX_ASCII = 94
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        wr_en,
  output logic [8:0]  wr_data,
  input  logic        wr_done,
  output logic        show_char_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_PIX_HI = 3'd2,
    S_PIX_LO = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [3:0] HDR_LAST  = 4'd10;

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  row_cnt_q, row_cnt_d;
  logic [7:0]  row_bits_q, row_bits_d;
  logic [6:0]  glyph_q, glyph_d;
  logic        size_q, size_d;
  logic [8:0]  xs_q, xs_d;
  logic [8:0]  ys_q, ys_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_data_q, wr_data_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [6:0]  glyph_in;
  logic [2:0]  col_last;
  logic [3:0]  row_last;
  logic [8:0]  xe;
  logic [8:0]  ye;
  logic        wd_ok;
  logic [2:0]  col_nxt;
  logic [3:0]  row_nxt;
  logic [3:0]  hdr_nxt;

  // ROM address of one font row: {size, glyph*H + row}, H = 12 or 16.
  function automatic logic [11:0] row_addr(input logic sz, input logic [6:0] g,
                                           input logic [3:0] r);
    logic [10:0] g11;
    logic [10:0] base;
    g11  = {4'b0000, g};
    base = sz ? (g11 << 4) : ((g11 << 3) + (g11 << 2));
    return {sz, base + {7'b0000000, r}};
  endfunction

  // One pixel byte: colour high byte or low byte, always sent as data.
  function automatic logic [8:0] pix_byte(input logic fg, input logic hi);
    logic [15:0] color;
    color = fg ? FG_COLOR : BG_COLOR;
    return {1'b1, hi ? color[15:8] : color[7:0]};
  endfunction

  // Window-setup header byte by position 0..10.
  function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                          input logic [8:0] x0, input logic [8:0] x1,
                                          input logic [8:0] y0, input logic [8:0] y1);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, CMD_CASET};
      4'd1:    b = {1'b1, 7'b0000000, x0[8]};
      4'd2:    b = {1'b1, x0[7:0]};
      4'd3:    b = {1'b1, 7'b0000000, x1[8]};
      4'd4:    b = {1'b1, x1[7:0]};
      4'd5:    b = {1'b0, CMD_RASET};
      4'd6:    b = {1'b1, 7'b0000000, y0[8]};
      4'd7:    b = {1'b1, y0[7:0]};
      4'd8:    b = {1'b1, 7'b0000000, y1[8]};
      4'd9:    b = {1'b1, y1[7:0]};
      default: b = {1'b0, CMD_RAMWR};
    endcase
    return b;
  endfunction

  // Geometry and helper values derived from the latched request.
  always_comb begin
    glyph_in = (ascii_num > 7'(MAX_ASCII)) ? 7'd0 : ascii_num;
    col_last = size_q ? 3'd7 : 3'd5;
    row_last = size_q ? 4'd15 : 4'd11;
    xe       = xs_q + (size_q ? 9'd7 : 9'd5);
    ye       = ys_q + (size_q ? 9'd15 : 9'd11);
    wd_ok    = pend_q && wr_done;
    col_nxt  = col_q + 3'd1;
    row_nxt  = row_cnt_q + 4'd1;
    hdr_nxt  = hdr_idx_q + 4'd1;
  end

  // Next-state logic: each accepted wr_done immediately queues the next byte.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hdr_idx_d  = hdr_idx_q;
    col_d      = col_q;
    row_cnt_d  = row_cnt_q;
    row_bits_d = row_bits_q;
    glyph_d    = glyph_q;
    size_d     = size_q;
    xs_d       = xs_q;
    ys_d       = ys_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        if (show_char_flag) begin
          glyph_d    = glyph_in;
          size_d     = en_size;
          xs_d       = start_x;
          ys_d       = start_y;
          // Row 0 is fetched now; the header gives the ROM ample time.
          rom_addr_d = row_addr(en_size, glyph_in, 4'd0);
          hdr_idx_d  = 4'd0;
          wr_en_d    = 1'b1;
          wr_data_d  = {1'b0, CMD_CASET};
          pend_d     = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_HDR;
        end
      end

      S_HDR: begin
        if (wd_ok) begin
          wr_en_d = 1'b1;
          pend_d  = 1'b1;
          if (hdr_idx_q == HDR_LAST) begin
            // First pixel uses rom_data directly while the row is captured.
            col_d      = 3'd0;
            row_cnt_d  = 4'd0;
            row_bits_d = rom_data;
            wr_data_d  = pix_byte(rom_data[0], 1'b1);
            state_d    = S_PIX_HI;
          end else begin
            hdr_idx_d = hdr_nxt;
            wr_data_d = hdr_byte(hdr_nxt, xs_q, xe, ys_q, ye);
          end
        end
      end

      S_PIX_HI: begin
        if (wd_ok) begin
          wr_en_d   = 1'b1;
          pend_d    = 1'b1;
          wr_data_d = pix_byte(row_bits_q[col_q], 1'b0);
          state_d   = S_PIX_LO;
          // Prefetch the next row during the last pixel of this one.
          if (col_q == col_last && row_cnt_q != row_last) begin
            rom_addr_d = row_addr(size_q, glyph_q, row_nxt);
          end
        end
      end

      S_PIX_LO: begin
        if (wd_ok) begin
          if (col_q == col_last) begin
            if (row_cnt_q == row_last) begin
              pend_d  = 1'b0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              wr_en_d    = 1'b1;
              pend_d     = 1'b1;
              col_d      = 3'd0;
              row_cnt_d  = row_nxt;
              row_bits_d = rom_data;
              wr_data_d  = pix_byte(rom_data[0], 1'b1);
              state_d    = S_PIX_HI;
            end
          end else begin
            wr_en_d   = 1'b1;
            pend_d    = 1'b1;
            col_d     = col_nxt;
            wr_data_d = pix_byte(row_bits_q[col_nxt], 1'b1);
            state_d   = S_PIX_HI;
          end
        end
      end

      S_DONE: begin
        // Flags in this cycle are deliberately dropped.
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        pend_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any glyph in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      hdr_idx_q  <= 4'd0;
      col_q      <= 3'd0;
      row_cnt_q  <= 4'd0;
      row_bits_q <= 8'd0;
      glyph_q    <= 7'd0;
      size_q     <= 1'b0;
      xs_q       <= 9'd0;
      ys_q       <= 9'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 9'd0;
      rom_addr_q <= 12'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      hdr_idx_q  <= hdr_idx_d;
      col_q      <= col_d;
      row_cnt_q  <= row_cnt_d;
      row_bits_q <= row_bits_d;
      glyph_q    <= glyph_d;
      size_q     <= size_d;
      xs_q       <= xs_d;
      ys_q       <= ys_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rom_addr_q <= rom_addr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_data        = wr_data_q;
  assign rom_addr       = rom_addr_q;
  assign show_char_done = done_q;
  assign busy           = busy_q;

endmodule
